// File: rtl/alu_mc_pkg.sv
// alu_pkg: shared types for the multi-cycle accumulator ALU (alu_mc).
// Holds the operation encoding and the control FSM state encoding.
package alu_pkg;

  // Number of op bits that carry a defined operation; wider op values are undefined.
  localparam int unsigned ALU_OP_BITS = 3;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_XOR  = 3'd3,
    OP_XNOR = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_MUL  = 3'd7
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: control and status signals of the accumulator ALU.
// The shared sysbus is a resolved tri-state net and stays a plain inout port.
interface alu_mc_if #(
  parameter int OP_W = 3
);

  logic            ACC_bus;
  logic            load_ACC;
  logic [OP_W-1:0] op;
  logic            z_flag;
  logic            c_flag;
  logic            busy;

  modport master (
    output ACC_bus,
    output load_ACC,
    output op,
    input  z_flag,
    input  c_flag,
    input  busy
  );

  modport slave (
    input  ACC_bus,
    input  load_ACC,
    input  op,
    output z_flag,
    output c_flag,
    output busy
  );

endinterface

// File: rtl/alu_mc_mul.sv
// alu_mul: unsigned shift-add multiplier, one partial product per cycle.
// start captures both operands; busy is high for exactly WORD_W cycles and
// done/product are valid together in the last busy cycle (low WORD_W bits only).
module alu_mul #(
  parameter int WORD_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] multiplicand,
  input  logic [WORD_W-1:0] multiplier,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] product
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] mcand_r;
  logic [WORD_W-1:0] mplier_r;
  logic [WORD_W-1:0] prod_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              busy_r;
  logic [WORD_W-1:0] prod_nxt_s;
  logic              done_s;

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    prod_nxt_s = prod_r;
    if (mplier_r[0]) begin
      prod_nxt_s = prod_r + mcand_r;
    end else begin
      prod_nxt_s = prod_r;
    end
  end

  assign done_s  = busy_r && (cnt_r == LAST_STEP);
  assign busy    = busy_r;
  assign done    = done_s;
  assign product = prod_nxt_s;

  // Operand capture and one shift-add step per busy cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_r  <= {WORD_W{1'b0}};
      mplier_r <= {WORD_W{1'b0}};
      prod_r   <= {WORD_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
    end else if (start && !busy_r) begin
      mcand_r  <= multiplicand;
      mplier_r <= multiplier;
      prod_r   <= {WORD_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      prod_r   <= prod_nxt_s;
      mcand_r  <= {mcand_r[WORD_W-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WORD_W-1:1]};
      if (done_s) begin
        cnt_r  <= {CNT_W{1'b0}};
        busy_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
        busy_r <= 1'b1;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: accumulator ALU on a shared tri-state system bus.
// Single-cycle LOAD/ADD/SUB/XOR/XNOR/SHL/SHR; multi-cycle MUL only when the
// ALU_MUL_EN macro is defined (otherwise op 7 is a no-op and busy is 0).
module alu_mc
  import alu_pkg::*;
#(
  parameter int WORD_W = 10,
  parameter int OP_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  inout  wire  [WORD_W-1:0] sysbus,
  alu_mc_if.slave           ctl
);

  logic [WORD_W-1:0] acc_r;
  logic [WORD_W-1:0] acc_nxt_s;
  logic              c_r;
  logic              c_nxt_s;
  logic              accept_s;
  logic              busy_s;
  logic              op_legal_s;
  alu_op_t           op_s;
  logic [WORD_W:0]   sum_s;
  logic [WORD_W:0]   diff_s;

  // Op values above the defined range leave all state untouched.
  assign op_legal_s = ((ctl.op >> ALU_OP_BITS) == {OP_W{1'b0}});
  assign op_s       = alu_op_t'(ctl.op[ALU_OP_BITS-1:0]);

  // The top bit of the extended difference is the unsigned borrow.
  assign sum_s  = {1'b0, acc_r} + {1'b0, sysbus};
  assign diff_s = {1'b0, acc_r} - {1'b0, sysbus};

  assign sysbus     = ctl.ACC_bus ? acc_r : {WORD_W{1'bz}};
  assign ctl.z_flag = (acc_r == {WORD_W{1'b0}});
  assign ctl.c_flag = c_r;
  assign ctl.busy   = busy_s;

`ifdef ALU_MUL_EN
  logic              mul_start_s;
  logic              mul_busy_s;
  logic              mul_done_s;
  logic [WORD_W-1:0] mul_prod_s;
  alu_state_t        state_r;

  assign accept_s = ctl.load_ACC && (state_r == ST_IDLE);
  assign busy_s   = mul_busy_s;

  alu_mul #(
    .WORD_W(WORD_W)
  ) u_mul (
    .clock       (clock),
    .reset       (reset),
    .start       (mul_start_s),
    .multiplicand(acc_r),
    .multiplier  (sysbus),
    .busy        (mul_busy_s),
    .done        (mul_done_s),
    .product     (mul_prod_s)
  );
`else
  assign accept_s = ctl.load_ACC;
  assign busy_s   = 1'b0;
`endif

  // Next accumulator/carry for single-cycle ops and MUL launch decode.
  always_comb begin
    acc_nxt_s = acc_r;
    c_nxt_s   = c_r;
`ifdef ALU_MUL_EN
    mul_start_s = 1'b0;
`endif
    if (accept_s && op_legal_s) begin
      case (op_s)
        OP_LOAD: acc_nxt_s = sysbus;
        OP_ADD: begin
          acc_nxt_s = sum_s[WORD_W-1:0];
          c_nxt_s   = sum_s[WORD_W];
        end
        OP_SUB: begin
          acc_nxt_s = diff_s[WORD_W-1:0];
          c_nxt_s   = diff_s[WORD_W];
        end
        OP_XOR:  acc_nxt_s = acc_r ^ sysbus;
        OP_XNOR: acc_nxt_s = ~(acc_r ^ sysbus);
        OP_SHL: begin
          acc_nxt_s = {acc_r[WORD_W-2:0], 1'b0};
          c_nxt_s   = acc_r[WORD_W-1];
        end
        OP_SHR: begin
          acc_nxt_s = {1'b0, acc_r[WORD_W-1:1]};
          c_nxt_s   = acc_r[0];
        end
        OP_MUL: begin
`ifdef ALU_MUL_EN
          mul_start_s = 1'b1;
`else
          acc_nxt_s = acc_r;
`endif
        end
        default: acc_nxt_s = acc_r;
      endcase
    end else begin
      acc_nxt_s = acc_r;
    end
  end

`ifdef ALU_MUL_EN
  // Control FSM: IDLE executes single-cycle ops, MUL holds acc until the product lands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r   <= {WORD_W{1'b0}};
      c_r     <= 1'b0;
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          acc_r   <= acc_nxt_s;
          c_r     <= c_nxt_s;
          state_r <= mul_start_s ? ST_MUL : ST_IDLE;
        end
        ST_MUL: begin
          if (mul_done_s) begin
            acc_r   <= mul_prod_s;
            state_r <= ST_IDLE;
          end else begin
            acc_r   <= acc_r;
            state_r <= ST_MUL;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
`else
  // Accumulator and carry update for single-cycle ops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r <= {WORD_W{1'b0}};
      c_r   <= 1'b0;
    end else begin
      acc_r <= acc_nxt_s;
      c_r   <= c_nxt_s;
    end
  end
`endif

endmodule
